// File: rtl/train_drive_ctrl.sv
// Train motor drive controller: ramped speed changes, standstill dwell before
// direction reversal, emergency stop, and a 7-step PWM drive output.
module train_drive_ctrl #(
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned DWELL_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] speed_req,
  input  logic       dir_req,
  input  logic       estop,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [2:0] speed_cur,
  output logic [2:0] state_o,
  output logic       busy
);

  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    DECEL  = 3'd2,
    CRUISE = 3'd3,
    DWELL  = 3'd4,
    ESTOP  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      speed_q, speed_d;
  logic            dir_q, dir_d;
  logic            pwm_q, pwm_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            ramp_tick;
  logic            dir_mis;
  logic [2:0]      tgt;

  always_comb begin
    ramp_tick = (presc_q == PRESC_MAX);
    presc_d   = ramp_tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d = (pwm_cnt_q == 3'd6) ? '0 : pwm_cnt_q + 3'd1;
    pwm_d     = (pwm_cnt_q < speed_q) && (state_q != ESTOP);
    dir_mis   = (dir_req != dir_q);
    tgt       = dir_mis ? '0 : speed_req;
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    dwell_d = '0;
    if (estop) begin
      state_d = ESTOP;
      speed_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dir_mis)          state_d = DWELL;
          else if (tgt != '0)   state_d = ACCEL;
        end
        ACCEL, DECEL, CRUISE: begin
          if (speed_q < tgt)        state_d = ACCEL;
          else if (speed_q > tgt)   state_d = DECEL;
          else if (speed_q != '0)   state_d = CRUISE;
          else if (dir_mis)         state_d = DWELL;
          else                      state_d = IDLE;
          // Step guarded by the live target so a mid-ramp reversal never overshoots
          if (ramp_tick) begin
            if (state_q == ACCEL && speed_q < tgt)      speed_d = speed_q + 3'd1;
            else if (state_q == DECEL && speed_q > tgt) speed_d = speed_q - 3'd1;
          end
        end
        DWELL: begin
          if (!dir_mis) begin
            state_d = IDLE;
          end else begin
            dwell_d = dwell_q;
            if (ramp_tick) begin
              if (dwell_q == DWELL_LAST) begin
                dir_d   = dir_req;
                state_d = IDLE;
                dwell_d = '0;
              end else begin
                dwell_d = dwell_q + DW'(1);
              end
            end
          end
        end
        ESTOP: begin
          if (speed_req == '0) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          speed_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      speed_q   <= '0;
      dir_q     <= 1'b1;
      pwm_q     <= 1'b0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      dwell_q   <= dwell_d;
    end
  end

  always_comb begin
    pwm_out   = pwm_q;
    dir_out   = dir_q;
    speed_cur = speed_q;
    state_o   = state_q;
    busy      = (state_q != IDLE) && (state_q != CRUISE);
  end

endmodule

// File: tb/tb_train_drive_ctrl.sv
// Scoreboard bench for train_drive_ctrl with RAMP_DIV=4, DWELL_TICKS=2:
// expectations are stamped with an edge index relative to the last reset.
module tb_train_drive_ctrl;

  localparam int S_STATE = 0;
  localparam int S_SPEED = 1;
  localparam int S_DIR   = 2;
  localparam int S_PWM   = 3;
  localparam int S_BUSY  = 4;

  logic       clk;
  logic       rst;
  logic [2:0] speed_req;
  logic       dir_req;
  logic       estop;
  logic       pwm_out;
  logic       dir_out;
  logic [2:0] speed_cur;
  logic [2:0] state_o;
  logic       busy;

  train_drive_ctrl #(.RAMP_DIV(4), .DWELL_TICKS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .speed_req (speed_req),
    .dir_req   (dir_req),
    .estop     (estop),
    .pwm_out   (pwm_out),
    .dir_out   (dir_out),
    .speed_cur (speed_cur),
    .state_o   (state_o),
    .busy      (busy)
  );

  typedef struct {
    int    stamp;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   edges    = 0;
  int   base     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stop_req = 1'b0;
  bit   mon_done = 1'b0;
  int   duty_exp [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  function automatic int actual(input int sel);
    case (sel)
      S_STATE: return int'(state_o);
      S_SPEED: return int'(speed_cur);
      S_DIR:   return int'(dir_out);
      S_PWM:   return int'(pwm_out);
      default: return int'(busy);
    endcase
  endfunction

  task automatic push_exp(input int j, input int sel, input int val, input string name);
    exp_t e;
    int   i;
    e.stamp = base + j;
    e.sel   = sel;
    e.val   = val;
    e.name  = name;
    i = 0;
    while (i < sb_q.size() && sb_q[i].stamp <= e.stamp) i++;
    sb_q.insert(i, e);
  endtask

  task automatic wait_to(input int j);
    while (edges < base + j) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = edges;
  endtask

  // Monitor: compares every expectation due at this edge index.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sb_q.size() > 0 && (stop_req || sb_q[0].stamp <= edges)) begin
      e = sb_q.pop_front();
      n_checks++;
      if (e.stamp != edges) begin
        $display("FAIL %s: sample not taken at edge %0d (now %0d), required %0d",
                 e.name, e.stamp, edges, e.val);
      end else begin
        act = actual(e.sel);
        if (act != e.val)
          $display("FAIL %s: got %0d expected %0d (edge %0d)", e.name, act, e.val, edges - base);
        else
          n_pass++;
      end
    end
    if (stop_req) mon_done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; speed_req = 3'd3; dir_req = 1'b1; estop = 1'b0;
    duty_exp = '{1, 1, 0, 0, 0, 1, 1};

    // Ramp up to 3, then to 7, then down to 0.
    do_reset();
    push_exp(0, S_STATE, 0, "rst_state");
    push_exp(0, S_SPEED, 0, "rst_speed");
    push_exp(0, S_DIR,   1, "rst_dir");
    push_exp(0, S_PWM,   0, "rst_pwm");
    push_exp(0, S_BUSY,  0, "rst_busy");
    push_exp(1, S_STATE, 1, "a_accel");
    push_exp(1, S_BUSY,  1, "a_busy");
    push_exp(3, S_SPEED, 0, "a_pre_tick");
    push_exp(4, S_SPEED, 1, "a_tick1");
    push_exp(7, S_SPEED, 1, "a_hold1");
    push_exp(8, S_SPEED, 2, "a_tick2");
    push_exp(12, S_SPEED, 3, "a_tick3");
    push_exp(12, S_STATE, 1, "a_still_accel");
    push_exp(13, S_STATE, 3, "a_cruise");
    push_exp(13, S_BUSY,  0, "a_cruise_busy");
    push_exp(15, S_STATE, 1, "b_accel");
    push_exp(16, S_SPEED, 4, "b_spd4");
    push_exp(20, S_SPEED, 5, "b_spd5");
    push_exp(24, S_SPEED, 6, "b_spd6");
    push_exp(28, S_SPEED, 7, "b_spd7");
    push_exp(29, S_STATE, 3, "b_cruise7");
    for (int j = 29; j <= 35; j++) push_exp(j, S_PWM, 1, "b_pwm_full");
    push_exp(37, S_STATE, 2, "b_decel");
    push_exp(40, S_SPEED, 6, "b_dec6");
    push_exp(40, S_BUSY,  1, "b_decel_busy");
    push_exp(63, S_SPEED, 1, "b_dec1");
    push_exp(64, S_SPEED, 0, "b_dec0");
    push_exp(64, S_STATE, 2, "b_still_decel");
    push_exp(65, S_STATE, 0, "b_idle");
    push_exp(65, S_DIR,   1, "b_dir");
    for (int j = 65; j <= 71; j++) push_exp(j, S_PWM, 0, "b_pwm_zero");
    wait_to(14); speed_req = 3'd7;
    wait_to(36); speed_req = 3'd0;
    wait_to(72);

    // Direction reversal through dwell.
    speed_req = 3'd2; dir_req = 1'b1;
    do_reset();
    push_exp(8,  S_SPEED, 2, "c_spd2");
    push_exp(9,  S_STATE, 3, "c_cruise");
    push_exp(11, S_STATE, 2, "c_decel");
    push_exp(12, S_SPEED, 1, "c_dec1");
    push_exp(16, S_SPEED, 0, "c_dec0");
    push_exp(16, S_DIR,   1, "c_dir_held");
    push_exp(17, S_STATE, 4, "c_dwell");
    push_exp(17, S_BUSY,  1, "c_dwell_busy");
    push_exp(23, S_STATE, 4, "c_dwell_hold");
    push_exp(23, S_DIR,   1, "c_dir_hold");
    push_exp(24, S_STATE, 0, "c_idle");
    push_exp(24, S_DIR,   0, "c_dir_flip");
    push_exp(25, S_STATE, 1, "c_reaccel");
    push_exp(28, S_SPEED, 1, "c_re1");
    push_exp(32, S_SPEED, 2, "c_re2");
    push_exp(33, S_STATE, 3, "c_recruise");
    wait_to(10); dir_req = 1'b0;
    wait_to(34);

    // Emergency stop from speed 5.
    speed_req = 3'd5; dir_req = 1'b1;
    do_reset();
    push_exp(20, S_SPEED, 5, "d_spd5");
    push_exp(21, S_STATE, 3, "d_cruise");
    push_exp(23, S_STATE, 5, "d_estop");
    push_exp(23, S_SPEED, 0, "d_estop_spd");
    push_exp(23, S_BUSY,  1, "d_estop_busy");
    push_exp(24, S_PWM,   0, "d_estop_pwm");
    push_exp(25, S_STATE, 5, "d_estop_hold");
    push_exp(27, S_STATE, 5, "d_estop_req4");
    push_exp(28, S_STATE, 5, "d_estop_req4b");
    push_exp(28, S_DIR,   1, "d_estop_dir");
    push_exp(29, S_STATE, 0, "d_exit_idle");
    push_exp(29, S_BUSY,  0, "d_exit_busy");
    push_exp(30, S_STATE, 0, "d_idle_stay");
    wait_to(22); estop = 1'b1;
    wait_to(25); estop = 1'b0; speed_req = 3'd4;
    wait_to(28); speed_req = 3'd0;
    wait_to(31);

    // PWM duty at speed 4 over one 7-clock period.
    speed_req = 3'd4; dir_req = 1'b1;
    do_reset();
    push_exp(16, S_SPEED, 4, "e_spd4");
    push_exp(17, S_STATE, 3, "e_cruise");
    for (int j = 0; j < 7; j++) push_exp(17 + j, S_PWM, duty_exp[j], "e_duty");
    wait_to(24);

    // Direction restored during dwell.
    speed_req = 3'd0; dir_req = 1'b0;
    do_reset();
    push_exp(0, S_DIR,   1, "f_rst_dir");
    push_exp(1, S_STATE, 4, "f_dwell");
    push_exp(5, S_STATE, 4, "f_dwell_hold");
    push_exp(5, S_DIR,   1, "f_dir_hold");
    push_exp(6, S_STATE, 0, "f_abort_idle");
    push_exp(6, S_DIR,   1, "f_dir_kept");
    push_exp(8, S_STATE, 0, "f_idle_stay");
    push_exp(8, S_DIR,   1, "f_dir_final");
    wait_to(5); dir_req = 1'b1;
    wait_to(9);

    // Reset mid-ACCEL aborts the ramp with no residual prescaler phase.
    speed_req = 3'd6; dir_req = 1'b1;
    do_reset();
    push_exp(1, S_STATE, 1, "g_accel");
    push_exp(8, S_SPEED, 2, "g_spd2");
    wait_to(8);
    do_reset();
    push_exp(0, S_STATE, 0, "g_rst_state");
    push_exp(0, S_SPEED, 0, "g_rst_speed");
    push_exp(0, S_PWM,   0, "g_rst_pwm");
    push_exp(0, S_DIR,   1, "g_rst_dir");
    push_exp(0, S_BUSY,  0, "g_rst_busy");
    push_exp(1, S_STATE, 1, "g_reaccel");
    push_exp(3, S_SPEED, 0, "g_no_early_tick");
    push_exp(4, S_SPEED, 1, "g_first_tick");
    wait_to(5);

    // Reset overrides a simultaneous estop.
    estop = 1'b1;
    do_reset();
    push_exp(0, S_STATE, 0, "h_rst_over_estop");
    push_exp(0, S_SPEED, 0, "h_rst_speed");
    push_exp(1, S_STATE, 5, "h_estop_after");
    wait_to(2);
    estop = 1'b0; speed_req = 3'd0;

    stop_req = 1'b1;
    for (int k = 0; k < 10 && !mon_done; k++) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
